cbsel_arb: RTL and testbench

- 4-source round-robin arbiter and output register, directly upstream of the 4:1 one-hot selector cbsel.
- Drives cbsel's one-hot select `d[3:0]` from per-source requests.
- Samples cbsel's selected word `o` back in as `sel_data` and presents it downstream through a valid/ready register stage.
- Guarantees `d` is always zero or exactly one-hot, and holds it stable for the whole sampling cycle.

---
 rtl/cbsel_arb.sv | 111 +++++++++++
 tb/tb_cbsel_arb.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/cbsel_arb.sv
// Round-robin arbiter driving the one-hot select of the cbsel 4:1 mux, with a
// valid/ready output register. Define CBSEL_ARB_FIXED_PRIO_EN for fixed priority (3 highest).
module cbsel_arb #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    output logic [3:0]       ack,
    output logic [3:0]       d,
    input  logic [WIDTH-1:0] sel_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_src
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic [1:0] state;
    logic [1:0] pick_idx;
    logic [1:0] d_idx;
    logic [3:0] pick_onehot;

`ifdef CBSEL_ARB_FIXED_PRIO_EN
    // Ascending scan so the highest requesting index is the one left standing.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        pick_idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (req[k]) pick_idx = 2'(k);
        end
    end
`else
    logic [1:0] ptr;
    logic [3:0] req_rot;
    logic [1:0] pick_off;

    // Rotate so that bit 0 of req_rot is source ptr, then take the lowest set bit.
    always_comb begin
        case (ptr)
            2'd0:    req_rot = req;
            2'd1:    req_rot = {req[0],   req[3:1]};
            2'd2:    req_rot = {req[1:0], req[3:2]};
            default: req_rot = {req[2:0], req[3]};
        endcase
        pick_off = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (req_rot[k]) pick_off = 2'(k);
        end
        pick_idx = ptr + pick_off;
    end
`endif

    assign pick_onehot = 4'b0001 << pick_idx;
    assign d_idx       = {d[3] | d[2], d[3] | d[1]};
    assign ack         = (state == GRANT) ? d : 4'b0000;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state     <= IDLE;
            d         <= 4'b0000;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 2'd0;
`ifndef CBSEL_ARB_FIXED_PRIO_EN
            ptr       <= 2'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        d     <= pick_onehot;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    // d has been stable all cycle, so sel_data is the granted source's word.
                    out_data  <= sel_data;
                    out_src   <= d_idx;
                    out_valid <= 1'b1;
`ifndef CBSEL_ARB_FIXED_PRIO_EN
                    ptr       <= d_idx + 2'd1;
`endif
                    d         <= 4'b0000;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (|req) begin
                            d     <= pick_onehot;
                            state <= GRANT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    d         <= 4'b0000;
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cbsel_arb.sv
// Directed bench for cbsel_arb: models the cbsel one-hot mux and checks the
// arbiter against hand-computed grant/data sequences.
module tb_cbsel_arb;

    localparam int WIDTH = 10;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       req;
    logic [3:0]       ack;
    logic [3:0]       d;
    logic [WIDTH-1:0] sel_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_src;

    logic [WIDTH-1:0] i0, i1, i2, i3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Model of the downstream cbsel one-hot AND-OR mux.
    assign sel_data = ({WIDTH{d[0]}} & i0) | ({WIDTH{d[1]}} & i1) |
                      ({WIDTH{d[2]}} & i2) | ({WIDTH{d[3]}} & i3);

    cbsel_arb #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .ack       (ack),
        .d         (d),
        .sel_data  (sel_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge, then sample clear of it; the one-hot invariant is checked every cycle.
    task automatic step();
        @(posedge clk);
        #1;
        check("d_onehot", 32'($countones(d) <= 1), 32'd1);
    endtask

    logic [WIDTH-1:0] rr_data [5];
    logic [3:0]       rr_d    [5];
    logic [1:0]       rr_src  [5];

    initial begin
`ifdef CBSEL_ARB_FIXED_PRIO_EN
        rr_data = '{10'd140, 10'd140, 10'd140, 10'd140, 10'd140};
        rr_d    = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000};
        rr_src  = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
`else
        rr_data = '{10'd18, 10'd12, 10'd15, 10'd140, 10'd18};
        rr_d    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_src  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`endif
        i0 = 10'd18; i1 = 10'd12; i2 = 10'd15; i3 = 10'd140;
        rst_n = 1'b0; req = 4'b0000; out_ready = 1'b1;

        // Reset and idle: out_ready high with nothing valid must be harmless.
        step(); step();
        check("rst_d", 32'(d), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        for (int n = 0; n < 5; n++) begin
            step();
            check("idle_d", 32'(d), 32'd0);
            check("idle_valid", 32'(out_valid), 32'd0);
            check("idle_data", 32'(out_data), 32'd0);
        end

        // Single source 2.
        req = 4'b0100;
        step();
        check("single_d", 32'(d), 32'b0100);
        check("single_ack", 32'(ack), 32'b0100);
        req = 4'b0000;
        step();
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_data", 32'(out_data), 32'd15);
        check("single_src", 32'(out_src), 32'd2);
        check("single_ack_low", 32'(ack), 32'd0);
        step();
        check("single_accept", 32'(out_valid), 32'd0);
        check("single_idle_d", 32'(d), 32'd0);

        // Round-robin from a fresh reset with all four requesting.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            step();
            check("rr_d", 32'(d), 32'(rr_d[n]));
            check("rr_ack", 32'(ack), 32'(rr_d[n]));
            check("rr_valid_gap", 32'(out_valid), 32'd0);
            if (n == 4) req = 4'b0000;
            step();
            check("rr_valid", 32'(out_valid), 32'd1);
            check("rr_data", 32'(out_data), 32'(rr_data[n]));
            check("rr_src", 32'(out_src), 32'(rr_src[n]));
            check("rr_hold_d", 32'(d), 32'd0);
        end
        step();
        check("rr_idle_valid", 32'(out_valid), 32'd0);
        check("rr_idle_d", 32'(d), 32'd0);

        // Backpressure on source 3; requests arriving during HOLD are ignored.
        out_ready = 1'b0;
        req = 4'b1000;
        step();
        check("bp_d", 32'(d), 32'b1000);
        req = 4'b1111;
        for (int n = 0; n < 6; n++) begin
            step();
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_data", 32'(out_data), 32'd140);
            check("bp_src", 32'(out_src), 32'd3);
            check("bp_hold_d", 32'(d), 32'd0);
        end
        req = 4'b0000;
        out_ready = 1'b1;
        step();
        check("bp_accept", 32'(out_valid), 32'd0);
        check("bp_idle_d", 32'(d), 32'd0);
        step();
        check("bp_single", 32'(out_valid), 32'd0);

        // One-cycle request from source 1 still completes.
        req = 4'b0010;
        step();
        check("drop_d", 32'(d), 32'b0010);
        check("drop_ack", 32'(ack), 32'b0010);
        req = 4'b0000;
        step();
        check("drop_valid", 32'(out_valid), 32'd1);
        check("drop_data", 32'(out_data), 32'd12);
        check("drop_src", 32'(out_src), 32'd1);
        step();
        check("drop_accept", 32'(out_valid), 32'd0);
        step();
        check("drop_idle_d", 32'(d), 32'd0);

        // Reset while holding a word discards it and restarts the pointer.
        out_ready = 1'b0;
        req = 4'b1000;
        step();
        req = 4'b0000;
        step();
        check("mrst_pre_data", 32'(out_data), 32'd140);
        rst_n = 1'b0;
        step();
        check("mrst_valid", 32'(out_valid), 32'd0);
        check("mrst_data", 32'(out_data), 32'd0);
        check("mrst_src", 32'(out_src), 32'd0);
        check("mrst_d", 32'(d), 32'd0);
        rst_n = 1'b1;
        req = 4'b1111;
        out_ready = 1'b1;
        step();
`ifdef CBSEL_ARB_FIXED_PRIO_EN
        check("mrst_first", 32'(d), 32'b1000);
`else
        check("mrst_first", 32'(d), 32'b0001);
`endif
        req = 4'b0000;
        step();
        check("mrst_first_valid", 32'(out_valid), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
